// File: rtl/lap_sequencer.sv
`default_nettype none
// ============================================================================
// lap_sequencer : issues alternating M/I pulses per lap once unlocked by E,
//                 counting steps/laps and faulting on timeout, lost unlock or stall
// Rev 1.0
// ============================================================================
module lap_sequencer #(
  parameter int STEPS     = 11,
  parameter int LAPS      = 2,
  parameter int TIMEOUT   = 8,
  parameter int MAX_STALL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       E,
  input  logic       P,
  input  logic [3:0] S_g,
  input  logic       FC,
  output logic       M,
  output logic       I,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [4:0] step_cnt,
  output logic [3:0] lap_cnt,
  output logic [3:0] secret_laps,
  output logic       fc_seen
);

  localparam logic [4:0] c_STEPS     = 5'(STEPS);
  localparam logic [3:0] c_LAPS      = 4'(LAPS);
  localparam logic [7:0] c_TIMEOUT   = 8'(TIMEOUT);
  localparam logic [3:0] c_MAX_STALL = 4'(MAX_STALL);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_STEP_M  = 3'd2,
    ST_STEP_I  = 3'd3,
    ST_LAP_END = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  state_t     r_state,  w_state_nxt;
  logic [4:0] r_step,   w_step_nxt;
  logic [3:0] r_lap,    w_lap_nxt;
  logic [3:0] r_secret, w_secret_nxt;
  logic       r_fc,     w_fc_nxt;
  logic [7:0] r_wait,   w_wait_nxt;
  logic [3:0] r_stall,  w_stall_nxt;
  logic [3:0] r_sprev,  w_sprev_nxt;

  logic [7:0] w_wait_inc;
  logic [3:0] w_stall_inc;
  logic [4:0] w_step_inc;
  logic [3:0] w_lap_inc;
  logic       w_same;
  logic       w_stall_fault;

  assign w_wait_inc    = r_wait + 8'd1;
  assign w_stall_inc   = r_stall + 4'd1;
  assign w_step_inc    = r_step + 5'd1;
  assign w_lap_inc     = r_lap + 4'd1;
  assign w_same        = (S_g == r_sprev);
  assign w_stall_fault = w_same && (w_stall_inc == c_MAX_STALL);

  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_lap_nxt    = r_lap;
    w_secret_nxt = r_secret;
    w_fc_nxt     = r_fc | (busy & FC);
    w_wait_nxt   = r_wait;
    w_stall_nxt  = r_stall;
    w_sprev_nxt  = r_sprev;

    // abort wins over every fault and step transition but leaves counters intact
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_fc_nxt    = r_fc;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_state_nxt  = ST_ARMED;
            w_step_nxt   = 5'd0;
            w_lap_nxt    = 4'd0;
            w_secret_nxt = 4'd0;
            w_fc_nxt     = 1'b0;
            w_wait_nxt   = 8'd0;
            w_stall_nxt  = 4'd0;
          end
        end
        ST_ARMED: begin
          if (E) begin
            w_state_nxt = ST_STEP_M;
          end else begin
            w_wait_nxt = w_wait_inc;
            if (w_wait_inc == c_TIMEOUT) w_state_nxt = ST_FAULT;
          end
        end
        ST_STEP_M: begin
          if (!E) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_sprev_nxt = S_g;
            w_state_nxt = ST_STEP_I;
          end
        end
        ST_STEP_I: begin
          if (!E) begin
            w_state_nxt = ST_FAULT;
          end else if (w_stall_fault) begin
            w_stall_nxt = w_stall_inc;
            w_state_nxt = ST_FAULT;
          end else begin
            w_stall_nxt = w_same ? w_stall_inc : 4'd0;
            w_step_nxt  = w_step_inc;
            w_state_nxt = (w_step_inc == c_STEPS) ? ST_LAP_END : ST_STEP_M;
          end
        end
        ST_LAP_END: begin
          if (!E) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_lap_nxt    = w_lap_inc;
            w_secret_nxt = P ? (r_secret + 4'd1) : r_secret;
            w_step_nxt   = 5'd0;
            w_state_nxt  = (w_lap_inc == c_LAPS) ? ST_DONE : ST_STEP_M;
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_step   <= 5'd0;
      r_lap    <= 4'd0;
      r_secret <= 4'd0;
      r_fc     <= 1'b0;
      r_wait   <= 8'd0;
      r_stall  <= 4'd0;
      r_sprev  <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_lap    <= w_lap_nxt;
      r_secret <= w_secret_nxt;
      r_fc     <= w_fc_nxt;
      r_wait   <= w_wait_nxt;
      r_stall  <= w_stall_nxt;
      r_sprev  <= w_sprev_nxt;
    end
  end

  assign M           = (r_state == ST_STEP_M);
  assign I           = (r_state == ST_STEP_I);
  assign busy        = (r_state == ST_ARMED) || (r_state == ST_STEP_M) ||
                       (r_state == ST_STEP_I) || (r_state == ST_LAP_END);
  assign done        = (r_state == ST_DONE);
  assign fault       = (r_state == ST_FAULT);
  assign step_cnt    = r_step;
  assign lap_cnt     = r_lap;
  assign secret_laps = r_secret;
  assign fc_seen     = r_fc;

endmodule
`default_nettype wire

// File: doc/lap_sequencer.md
# lap_sequencer

Autonomous driver for the main game FSM. Replaces manual toggling of M/I with a controlled sequence. After `start` and unlock (`E` from the start-sequence machine), it issues alternating one-cycle M and I pulses for a fixed number of steps per lap. It also counts laps, captures the secret-mode flag (`P`) per lap, and faults on unlock timeout, lost unlock or stalled FSM state.

## Interface
- `STEPS`, 11: M/I pulse pairs per lap; legal range 1..31.
- `LAPS`, 2: laps per run; legal range 1..15.
- `TIMEOUT`, 8: cycles allowed in ARMED waiting for `E`; legal range 1..255.
- `MAX_STALL`, 2: consecutive stalled steps that cause FAULT; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `abort` in 1: return to IDLE from any state; highest priority after `rst`.
- `E` in 1: unlock flag from the start-sequence machine.
- `P` in 1: secret-mode flag from the secret-code machine.
- `S_g` in 4: main FSM state, used for stall detection.
- `FC` in 1: full-completion flag from the main FSM.
- `M` out 1: M drive to the main FSM.
- `I` out 1: I drive to the main FSM.
- `busy` out 1: high in ARMED, STEP_M, STEP_I and LAP_END.
- `done` out 1: high while in DONE.
- `fault` out 1: high while in FAULT.
- `step_cnt` out 5: completed steps in the current lap.
- `lap_cnt` out 4: completed laps.
- `secret_laps` out 4: completed laps with `P`=1 at LAP_END.
- `fc_seen` out 1: sticky; set if `FC`=1 in any busy cycle of the run.

## Operation
- States: IDLE, ARMED, STEP_M, STEP_I, LAP_END, DONE, FAULT.
- All outputs are registered or decoded from the state register only. No combinational path from inputs to outputs.
- Reset value of every output is 0; state resets to IDLE.
- IDLE:
  - `M`=`I`=0.
  - `start`=1 → ARMED. On that transition, clear `step_cnt`, `lap_cnt`, `secret_laps`, `fc_seen`, wait counter and stall counter.
- ARMED:
  - `E`=1 → STEP_M.
  - Otherwise increment the wait counter. Wait counter reaching `TIMEOUT` → FAULT.
- STEP_M:
  - `M`=1, `I`=0 for exactly one cycle, then → STEP_I.
  - Latch `S_g` into `s_prev`.
- STEP_I:
  - `M`=0, `I`=1 for exactly one cycle.
  - If `S_g`==`s_prev`, increment the stall counter; otherwise clear it.
  - Stall counter reaching `MAX_STALL` → FAULT.
  - Otherwise increment `step_cnt`. Go to LAP_END if the new value equals `STEPS`, else STEP_M.
- LAP_END:
  - `M`=`I`=0 for one cycle.
  - Increment `lap_cnt`; increment `secret_laps` if `P`=1; clear `step_cnt`.
  - New `lap_cnt`==`LAPS` → DONE, else STEP_M.
- DONE:
  - Counters hold.
  - `start`=1 → ARMED, with the same clears as from IDLE.
- FAULT:
  - `M`=`I`=0; counters freeze at their fault-time values.
  - Exit only via `abort` or `rst` → IDLE.
- Lost unlock: `E`=0 in any STEP_M, STEP_I or LAP_END cycle → FAULT at the next edge. This check takes priority over stall and count transitions.
- Priority per edge: `rst` > `abort` > lost-unlock/timeout/stall fault > normal transition.
- `start` is ignored outside IDLE and DONE.
- `abort` in IDLE: stays in IDLE with no other effect.
- `abort` outside IDLE clears `done` and `fault` but leaves counters as they are. Counters are cleared only on the next `start`.

## Timing
- `start` sampled at edge 0 → ARMED during cycle 1.
- With `E`=1, first `M`=1 cycle is cycle 2.
- Each lap takes 2·`STEPS`+1 cycles.
- Run latency from the start edge to the first DONE cycle: 1 + `LAPS`·(2·`STEPS`+1) cycles, plus any extra ARMED wait cycles.
- `M` and `I` are never high in the same cycle. They are never high outside STEP_M and STEP_I.
- Timeout: with `E` held 0, FAULT is entered in cycle 1+`TIMEOUT`.
- Counter updates become visible the cycle after the edge that causes them.

## Test plan
- Nominal run:
  - Setup: `STEPS`=3, `LAPS`=2, `E`=1, `S_g` changes every step, `P`=0, start pulse at cycle 0.
  - `M`=1 in cycles 2, 4, 6, 9, 11, 13.
  - `I`=1 in cycles 3, 5, 7, 10, 12, 14.
  - `done`=1 from cycle 16; `lap_cnt`=2, `secret_laps`=0, `busy`=0.
- Unlock timeout:
  - Setup: `TIMEOUT`=4, `E`=0, start at cycle 0.
  - `fault`=1 at cycle 5; `M`=`I`=0 throughout.
  - `abort` → IDLE with all flags 0.
- Stall detection:
  - Setup: `MAX_STALL`=2, `S_g` held constant at 1.
  - FAULT follows the second STEP_I cycle.
  - `step_cnt`=1 at fault; no further M/I pulses.
- Lost unlock mid-lap:
  - Stimulus: drop `E` during the second STEP_M.
  - FAULT at the next edge; `I` is not asserted for that step; `step_cnt`=1.
- Secret and FC tracking:
  - Stimulus: `P`=1 only during lap 2's LAP_END; `FC` pulsed once during lap 1.
  - Response: `secret_laps`=1, `fc_seen`=1 held through DONE.
  - Restart with `start` from DONE clears `fc_seen`, `secret_laps` and `lap_cnt`.
- Reset and priority:
  - `rst` asserted in STEP_I → next cycle IDLE with all outputs 0.
  - `abort` and a stall fault on the same edge → IDLE, not FAULT.
